// File: rtl/alu_trainer.sv
// Switch ALU trainer: synchronised operands/opcode, registered result/flags, debounced key
// accumulator (op 7) and blink divider. Define ALU_TRAINER_SAT_EN for saturating add/sub/acc.
module alu_trainer #(
  parameter int unsigned W          = 4,
  parameter int unsigned DB_CNT     = 500000,
  parameter int unsigned BLINK_BITS = 25
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [W-1:0] din_0,
  input  logic [W-1:0] din_1,
  input  logic [2:0]   sel,
  input  logic         key_n,
  output logic [W-1:0] dout,
  output logic         carry,
  output logic         zero,
  output logic         key_evt,
  output logic         blink
);

  localparam int unsigned      DbW   = $clog2(DB_CNT);
  localparam logic [DbW-1:0]   DbMax = DbW'(DB_CNT - 1);

  logic [W-1:0] din_0_d1_q, din_0_d2_q, din_1_d1_q, din_1_d2_q;
  logic [2:0]   sel_d1_q, sel_d2_q;
  logic         key_n_d1_q, key_n_d2_q;

  logic [DbW-1:0]        db_cnt_q, db_cnt_d;
  logic                  key_lvl_q, key_lvl_d;
  logic [1:0]            prime_q, prime_d;
  logic                  armed_q, armed_d;
  logic                  key_evt_q, key_evt_d;
  logic [W-1:0]          acc_q, acc_d;
  logic                  acc_c_q, acc_c_d;
  logic                  sel7_q, sel7_d;
  logic [W-1:0]          dout_q, dout_d;
  logic                  carry_q, carry_d;
  logic                  zero_q, zero_d;
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;

  logic [W:0]   sum, diff, acc_sum;
  logic [W-1:0] add_res, sub_res, acc_res;

  always_comb begin
    sum     = {1'b0, din_0_d2_q} + {1'b0, din_1_d2_q};
    diff    = {1'b0, din_0_d2_q} - {1'b0, din_1_d2_q};
    acc_sum = {1'b0, acc_q} + {1'b0, din_0_d2_q};
`ifdef ALU_TRAINER_SAT_EN
    add_res = sum[W] ? '1 : sum[W-1:0];
    sub_res = diff[W] ? '0 : diff[W-1:0];
    acc_res = acc_sum[W] ? '1 : acc_sum[W-1:0];
`else
    add_res = sum[W-1:0];
    sub_res = diff[W-1:0];
    acc_res = acc_sum[W-1:0];
`endif
  end

  // Debouncer; events are suppressed until the key has been seen released after reset.
  always_comb begin
    db_cnt_d  = db_cnt_q;
    key_lvl_d = key_lvl_q;
    if (key_n_d2_q == key_lvl_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbMax) begin
      key_lvl_d = key_n_d2_q;
      db_cnt_d  = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    prime_d   = {prime_q[0], 1'b1};
    armed_d   = armed_q | (prime_q[1] & key_n_d2_q);
    key_evt_d = armed_q & key_lvl_q & ~key_lvl_d;
  end

  always_comb begin
    sel7_d  = (sel_d2_q == 3'd7);
    acc_d   = acc_q;
    acc_c_d = acc_c_q;
    if (sel7_d && !sel7_q) begin
      acc_d   = '0;
      acc_c_d = 1'b0;
    end else if (sel7_d && key_evt_q) begin
      acc_d   = acc_res;
      acc_c_d = acc_sum[W];
    end

    dout_d  = '0;
    carry_d = 1'b0;
    unique case (sel_d2_q)
      3'd0: dout_d = din_0_d2_q;
      3'd1: dout_d = din_1_d2_q;
      3'd2: begin
        dout_d  = add_res;
        carry_d = sum[W];
      end
      3'd3: dout_d = din_0_d2_q | din_1_d2_q;
      3'd4: begin
        dout_d  = sub_res;
        carry_d = diff[W];
      end
      3'd5: dout_d = din_0_d2_q & din_1_d2_q;
      3'd6: dout_d = din_0_d2_q ^ din_1_d2_q;
      3'd7: begin
        dout_d  = acc_d;
        carry_d = acc_c_d;
      end
      default: ;
    endcase
    zero_d      = (dout_d == '0);
    blink_cnt_d = blink_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      din_0_d1_q  <= '0;
      din_0_d2_q  <= '0;
      din_1_d1_q  <= '0;
      din_1_d2_q  <= '0;
      sel_d1_q    <= '0;
      sel_d2_q    <= '0;
      key_n_d1_q  <= 1'b1;
      key_n_d2_q  <= 1'b1;
      db_cnt_q    <= '0;
      key_lvl_q   <= 1'b1;
      prime_q     <= '0;
      armed_q     <= 1'b0;
      key_evt_q   <= 1'b0;
      acc_q       <= '0;
      acc_c_q     <= 1'b0;
      sel7_q      <= 1'b0;
      dout_q      <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      din_0_d1_q  <= din_0;
      din_0_d2_q  <= din_0_d1_q;
      din_1_d1_q  <= din_1;
      din_1_d2_q  <= din_1_d1_q;
      sel_d1_q    <= sel;
      sel_d2_q    <= sel_d1_q;
      key_n_d1_q  <= key_n;
      key_n_d2_q  <= key_n_d1_q;
      db_cnt_q    <= db_cnt_d;
      key_lvl_q   <= key_lvl_d;
      prime_q     <= prime_d;
      armed_q     <= armed_d;
      key_evt_q   <= key_evt_d;
      acc_q       <= acc_d;
      acc_c_q     <= acc_c_d;
      sel7_q      <= sel7_d;
      dout_q      <= dout_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign dout    = dout_q;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign key_evt = key_evt_q;
  assign blink   = blink_cnt_q[BLINK_BITS-1];

endmodule

// File: tb/tb_alu_trainer.sv
// Scoreboard bench for alu_trainer (W=4, DB_CNT=4, BLINK_BITS=4): stimulus queues
// cycle-stamped expectations, a negedge monitor pops and compares them.
module tb_alu_trainer;

  logic       clk;
  logic       n_rst;
  logic [3:0] din_0, din_1;
  logic [2:0] sel;
  logic       key_n;
  logic [3:0] dout;
  logic       carry, zero, key_evt, blink;

  alu_trainer #(.W(4), .DB_CNT(4), .BLINK_BITS(4)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .din_0   (din_0),
    .din_1   (din_1),
    .sel     (sel),
    .key_n   (key_n),
    .dout    (dout),
    .carry   (carry),
    .zero    (zero),
    .key_evt (key_evt),
    .blink   (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind 0: {zero,carry,dout}; 1: key_evt; 2: blink; 3: key_evt pulse count so far
  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] got;
  int          cyc = 0;
  int          evt_cnt = 0;
  int          checks = 0;
  int          passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int k, input int v, input string nm);
    exp_t e;
    int   i;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic exp_out(input int c, input string nm, input int d, input int cy);
    push(c, 0, ((d == 0) ? 32 : 0) + ((cy != 0) ? 16 : 0) + (d % 16), nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (key_evt === 1'b1) evt_cnt++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        0:       got = {26'd0, zero, carry, dout};
        1:       got = {31'd0, key_evt};
        2:       got = {31'd0, blink};
        default: got = evt_cnt;
      endcase
      checks++;
      if (got !== mon_e.val || mon_e.cyc != cyc)
        $display("FAIL %s @cyc %0d (due %0d): got 0x%0h, expected 0x%0h",
                 mon_e.name, cyc, mon_e.cyc, got, mon_e.val);
      else passes++;
    end
  end

  int va[11] = '{9, 2, 5, 12, 12, 12, 12, 12, 5, 15, 0};
  int vb[11] = '{9, 5, 2, 10, 10, 10, 10, 10, 5, 1, 0};
  int vs[11] = '{2, 4, 4, 0, 1, 3, 5, 6, 6, 2, 4};
`ifdef ALU_TRAINER_SAT_EN
  int vd[11] = '{15, 0, 3, 12, 10, 14, 8, 6, 0, 15, 0};
  int acc3   = 15;
`else
  int vd[11] = '{2, 13, 3, 12, 10, 14, 8, 6, 0, 0, 0};
  int acc3   = 2;
`endif
  int vc[11] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  task automatic press(input int d, input int cy, input string nm);
    int m;
    m = cyc;
    key_n = 1'b0;
    push(m + 6, 1, 1, {nm, "_evt"});
    exp_out(m + 7, nm, d, cy);
    tick(8);
    key_n = 1'b1;
    tick(8);
  endtask

  initial begin
    int n;
    int r;
    int s;
    n_rst = 1'b0;
    key_n = 1'b1;
    din_0 = '0;
    din_1 = '0;
    sel   = '0;
    tick(3);
    exp_out(cyc, "reset_out", 0, 0);
    push(cyc, 1, 0, "reset_evt");
    push(cyc, 2, 0, "reset_blink");
    n_rst = 1'b1;
    r = cyc;
    push(r + 7, 2, 0, "blink_low_7");
    push(r + 8, 2, 1, "blink_high_8");
    push(r + 15, 2, 1, "blink_high_15");
    push(r + 16, 2, 0, "blink_low_16");
    push(r + 24, 2, 1, "blink_high_24");

    tick(1);
    n = cyc;
    din_0 = 4'd3;
    din_1 = 4'd5;
    sel   = 3'd2;
    exp_out(n + 2, "add_not_early", 0, 0);
    exp_out(n + 3, "add_3_5", 8, 0);
    tick(3);

    // One vector per cycle: each result lands three edges after it is applied
    for (int i = 0; i < 11; i++) begin
      n = cyc;
      din_0 = va[i][3:0];
      din_1 = vb[i][3:0];
      sel   = vs[i][2:0];
      exp_out(n + 3, $sformatf("op%0d_vec%0d", vs[i], i), vd[i], vc[i]);
      tick(1);
    end
    tick(3);

    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(8);
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(8);
    push(cyc, 3, 0, "short_pulses_no_evt");

    n = cyc;
    key_n = 1'b0;
    push(n + 5, 1, 0, "evt_not_early");
    push(n + 6, 1, 1, "evt_at_2_plus_db");
    push(n + 7, 1, 0, "evt_one_cycle");
    tick(20);
    key_n = 1'b1;
    tick(12);
    push(cyc, 3, 1, "hold_one_evt_release_none");

    n = cyc;
    din_0 = 4'd6;
    din_1 = 4'd0;
    sel   = 3'd7;
    exp_out(n + 3, "acc_entry_clear", 0, 0);
    tick(4);
    exp_out(cyc + 6, "acc_not_early", 0, 0);
    press(6, 0, "acc_press1");
    press(12, 0, "acc_press2");
    press(acc3, 1, "acc_press3_wrap");

    n = cyc;
    sel = 3'd0;
    exp_out(n + 3, "exit_to_op0", 6, 0);
    tick(4);
    n = cyc;
    sel = 3'd7;
    exp_out(n + 3, "reentry_clear", 0, 0);
    tick(4);

    // Key event lands on the same edge as op-7 entry: clear must win
    sel = 3'd0;
    tick(4);
    key_n = 1'b0;
    tick(4);
    s = cyc;
    sel = 3'd7;
    push(s + 2, 1, 1, "evt_on_entry");
    exp_out(s + 3, "entry_beats_evt", 0, 0);
    exp_out(s + 6, "entry_beats_evt_hold", 0, 0);
    tick(4);
    key_n = 1'b1;
    tick(10);
    push(cyc, 3, 5, "evt_total");

    sel = 3'd0;
    tick(4);
    key_n = 1'b0;
    tick(3);
    n_rst = 1'b0;
    exp_out(cyc, "async_rst_out", 0, 0);
    push(cyc, 1, 0, "async_rst_evt");
    push(cyc, 2, 0, "async_rst_blink");
    tick(2);
    n_rst = 1'b1;
    tick(20);
    push(cyc, 3, 5, "no_evt_key_held_through_reset");
    key_n = 1'b1;
    tick(10);
    n = cyc;
    key_n = 1'b0;
    push(n + 6, 1, 1, "evt_after_rearm");
    tick(12);
    key_n = 1'b1;
    tick(10);
    push(cyc, 3, 6, "evt_total_final");
    tick(2);

    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    checks++;
    $display("FAIL watchdog: stimulus still running at cycle %0d, expected done", cyc);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
